// File: rtl/filter_coef_loader.sv
// Reader side of the rotating coefficient ROM interface.
// Steps the ROM through one full rotation, capturing n1, n2, n3, d1, d2,
// and presents them in parallel with valid/busy/done status.
// Optional build macro FILTER_COEF_LOADER_DBUF_EN: capture into shadow
// registers and commit the whole bank at once, so coef_valid never drops.
module filter_coef_loader #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_COEF = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rom_data,
    output logic             rom_enable,
    output logic [WIDTH-1:0] coef_n1,
    output logic [WIDTH-1:0] coef_n2,
    output logic [WIDTH-1:0] coef_n3,
    output logic [WIDTH-1:0] coef_d1,
    output logic [WIDTH-1:0] coef_d2,
    output logic             coef_valid,
    output logic             busy,
    output logic             done,
    output logic             phase_err
);

    // Slot decode and the mod-5 phase tracker below assume exactly five words.
    if (NUM_COEF != 5) begin : g_bad_num_coef
        $error("filter_coef_loader: NUM_COEF must be 5");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [2:0] LastSlot  = 3'd4;
    localparam logic [2:0] LastPhase = 3'd4;

    state_e     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [2:0] phase_q, phase_d;
    logic       phase_err_q, phase_err_d;
    logic       rom_enable_q, rom_enable_d;
    logic       valid_q;

    logic [WIDTH-1:0] coef_n1_q, coef_n2_q, coef_n3_q, coef_d1_q, coef_d2_q;

    logic capture;
    logic last_capture;
    logic load_accept;

    assign capture      = (state_q == StLoad);
    assign last_capture = capture && (slot_q == LastSlot);
    assign load_accept  = (state_q == StIdle) && start;

    // Next-state, slot index, phase tracker and sticky error.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        phase_err_d = phase_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    slot_d  = 3'd0;
                    // ROM head should be n1 here; anything else means lost alignment.
                    if (phase_q != 3'd0) begin
                        phase_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (slot_q == LastSlot) begin
                    state_d = StDone;
                    slot_d  = 3'd0;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                slot_d  = 3'd0;
            end
        endcase
        // Registered strobe: high for exactly the cycles spent in LOAD.
        rom_enable_d = (state_d == StLoad);
        // Track the ROM's own rotation: it advances on every enabled cycle.
        if (rom_enable_q) begin
            phase_d = (phase_q == LastPhase) ? 3'd0 : phase_q + 3'd1;
        end else begin
            phase_d = phase_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            slot_q       <= 3'd0;
            phase_q      <= 3'd0;
            phase_err_q  <= 1'b0;
            rom_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            phase_q      <= phase_d;
            phase_err_q  <= phase_err_d;
            rom_enable_q <= rom_enable_d;
        end
    end

`ifdef FILTER_COEF_LOADER_DBUF_EN
    logic [WIDTH-1:0] sh_n1_q, sh_n2_q, sh_n3_q, sh_d1_q;

    // Shadow capture of slots 0..3; d2 arrives on the commit edge itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_n1_q <= '0;
            sh_n2_q <= '0;
            sh_n3_q <= '0;
            sh_d1_q <= '0;
        end else if (capture) begin
            case (slot_q)
                3'd0:    sh_n1_q <= rom_data;
                3'd1:    sh_n2_q <= rom_data;
                3'd2:    sh_n3_q <= rom_data;
                3'd3:    sh_d1_q <= rom_data;
                default: ;
            endcase
        end
    end

    // Commit all five outputs together so the bank is visible in the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            coef_n1_q <= '0;
            coef_n2_q <= '0;
            coef_n3_q <= '0;
            coef_d1_q <= '0;
            coef_d2_q <= '0;
            valid_q   <= 1'b0;
        end else if (last_capture) begin
            coef_n1_q <= sh_n1_q;
            coef_n2_q <= sh_n2_q;
            coef_n3_q <= sh_n3_q;
            coef_d1_q <= sh_d1_q;
            coef_d2_q <= rom_data;
            valid_q   <= 1'b1;
        end
    end
`else
    // Direct capture: each output follows its slot one cycle after capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            coef_n1_q <= '0;
            coef_n2_q <= '0;
            coef_n3_q <= '0;
            coef_d1_q <= '0;
            coef_d2_q <= '0;
        end else if (capture) begin
            case (slot_q)
                3'd0:    coef_n1_q <= rom_data;
                3'd1:    coef_n2_q <= rom_data;
                3'd2:    coef_n3_q <= rom_data;
                3'd3:    coef_d1_q <= rom_data;
                3'd4:    coef_d2_q <= rom_data;
                default: ;
            endcase
        end
    end

    // Bank is inconsistent from load acceptance until the last word lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (load_accept) begin
            valid_q <= 1'b0;
        end else if (last_capture) begin
            valid_q <= 1'b1;
        end
    end
`endif

    assign rom_enable = rom_enable_q;
    assign coef_n1    = coef_n1_q;
    assign coef_n2    = coef_n2_q;
    assign coef_n3    = coef_n3_q;
    assign coef_d1    = coef_d1_q;
    assign coef_d2    = coef_d2_q;
    assign coef_valid = valid_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign phase_err  = phase_err_q;

endmodule

// File: tb/tb_filter_coef_loader.sv
// Directed bench for filter_coef_loader with a rotating ROM model.
// Honours FILTER_COEF_LOADER_DBUF_EN for the bank-update timing checks.
module tb_filter_coef_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] rom_data;
    logic        rom_enable;
    logic [31:0] coef_n1, coef_n2, coef_n3, coef_d1, coef_d2;
    logic        coef_valid, busy, done, phase_err;

    int tests;
    int fails;

    // Rotating ROM model: head advances on rom_enable or a bench-forced stray step.
    logic [31:0] rom_mem [5];
    logic [2:0]  rom_ptr;
    logic        stray;

    filter_coef_loader #(.WIDTH(32), .NUM_COEF(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rom_data   (rom_data),
        .rom_enable (rom_enable),
        .coef_n1    (coef_n1),
        .coef_n2    (coef_n2),
        .coef_n3    (coef_n3),
        .coef_d1    (coef_d1),
        .coef_d2    (coef_d2),
        .coef_valid (coef_valid),
        .busy       (busy),
        .done       (done),
        .phase_err  (phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM head pointer, reset together with the loader.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_ptr <= 3'd0;
        end else if (rom_enable || stray) begin
            rom_ptr <= (rom_ptr == 3'd4) ? 3'd0 : rom_ptr + 3'd1;
        end
    end
    assign rom_data = rom_mem[rom_ptr];

    typedef struct {
        logic [31:0] rn1, rn2, rn3, rd1, rd2;  // ROM contents
        logic [31:0] en1, en2, en3, ed1, ed2;  // expected bank
        bit          mid_start;                // pulse start during LOAD
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_rom(input logic [31:0] a, b, c, d, e);
        rom_mem[0] = a;
        rom_mem[1] = b;
        rom_mem[2] = c;
        rom_mem[3] = d;
        rom_mem[4] = e;
    endtask

    task automatic check_bank(input string tag, input logic [31:0] n1, n2, n3, d1, d2);
        check({tag, ".n1"}, coef_n1, n1);
        check({tag, ".n2"}, coef_n2, n2);
        check({tag, ".n3"}, coef_n3, n3);
        check({tag, ".d1"}, coef_d1, d1);
        check({tag, ".d2"}, coef_d2, d2);
    endtask

    // One start pulse, then watch a bounded 12-cycle window.
    task automatic run_load(input string tag, input logic [31:0] n1, n2, n3, d1, d2,
                            input logic exp_perr, input bit mid_start);
        int en_cnt, first_en, last_en, done_at, done_cnt;
        en_cnt = 0; first_en = 0; last_en = 0; done_at = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (mid_start && i == 2) start = 1'b1;
            if (mid_start && i == 3) start = 1'b0;
            if (rom_enable) begin
                en_cnt++;
                if (first_en == 0) first_en = i;
                last_en = i;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (i == 1) check({tag, ".busy_load"}, {31'd0, busy}, 32'd1);
            if (i == 7) check({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
        end
        check({tag, ".en_count"}, en_cnt, 32'd5);
        check({tag, ".en_first"}, first_en, 32'd1);
        check({tag, ".en_last"}, last_en, 32'd5);
        check({tag, ".done_at"}, done_at, 32'd6);
        check({tag, ".done_count"}, done_cnt, 32'd1);
        check_bank(tag, n1, n2, n3, d1, d2);
        check({tag, ".valid"}, {31'd0, coef_valid}, 32'd1);
        check({tag, ".phase_err"}, {31'd0, phase_err}, {31'd0, exp_perr});
        check({tag, ".rom_head"}, rom_data, n1);
    endtask

    localparam logic [31:0] A0 = 32'h0001_0000, A1 = 32'hFFFE_2EF4, A2 = 32'h0000_E0F9,
                            A3 = 32'h0001_E339, A4 = 32'hFFFF_1C99;
    localparam logic [31:0] B0 = 32'h8000_0000, B1 = 32'h7FFF_FFFF, B2 = 32'h0000_0000,
                            B3 = 32'hFFFF_FFFF, B4 = 32'h1234_5678;

    initial begin
        vec_t vecs [3];
        tests = 0;
        fails = 0;
        start = 1'b0;
        stray = 1'b0;
        reset = 1'b1;
        set_rom(A0, A1, A2, A3, A4);

        vecs[0] = '{rn1: A0, rn2: A1, rn3: A2, rd1: A3, rd2: A4,
                    en1: 32'h0001_0000, en2: 32'hFFFE_2EF4, en3: 32'h0000_E0F9,
                    ed1: 32'h0001_E339, ed2: 32'hFFFF_1C99, mid_start: 1'b0};
        vecs[1] = '{rn1: A0, rn2: A1, rn3: A2, rd1: A3, rd2: A4,
                    en1: 32'h0001_0000, en2: 32'hFFFE_2EF4, en3: 32'h0000_E0F9,
                    ed1: 32'h0001_E339, ed2: 32'hFFFF_1C99, mid_start: 1'b1};
        vecs[2] = '{rn1: B0, rn2: B1, rn3: B2, rd1: B3, rd2: B4,
                    en1: 32'h8000_0000, en2: 32'h7FFF_FFFF, en3: 32'h0000_0000,
                    ed1: 32'hFFFF_FFFF, ed2: 32'h1234_5678, mid_start: 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        check_bank("reset", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check("reset.valid", {31'd0, coef_valid}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.rom_enable", {31'd0, rom_enable}, 32'd0);
        check("reset.phase_err", {31'd0, phase_err}, 32'd0);
        reset = 1'b0;

        // Table-driven full loads.
        for (int v = 0; v < 3; v++) begin
            set_rom(vecs[v].rn1, vecs[v].rn2, vecs[v].rn3, vecs[v].rd1, vecs[v].rd2);
            run_load($sformatf("vec%0d", v), vecs[v].en1, vecs[v].en2, vecs[v].en3,
                     vecs[v].ed1, vecs[v].ed2, 1'b0, vecs[v].mid_start);
        end

        // Reload bank A over bank B and watch the output bank during LOAD.
        set_rom(A0, A1, A2, A3, A4);
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
`ifdef FILTER_COEF_LOADER_DBUF_EN
            if (i <= 5) begin
                check($sformatf("dbuf.c%0d.valid", i), {31'd0, coef_valid}, 32'd1);
                check($sformatf("dbuf.c%0d.n1", i), coef_n1, B0);
                check($sformatf("dbuf.c%0d.d2", i), coef_d2, B4);
            end
`else
            if (i <= 5) check($sformatf("direct.c%0d.valid", i), {31'd0, coef_valid}, 32'd0);
            if (i == 1) check("direct.c1.n1", coef_n1, B0);
            if (i == 2) check("direct.c2.n1", coef_n1, A0);
            if (i == 2) check("direct.c2.d2", coef_d2, B4);
`endif
            if (i == 6) begin
                check("swap.done", {31'd0, done}, 32'd1);
                check("swap.valid", {31'd0, coef_valid}, 32'd1);
                check_bank("swap", A0, A1, A2, A3, A4);
            end
        end

        // Reset in the third LOAD cycle, then a clean load.
        set_rom(B0, B1, B2, B3, B4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_bank("midrst", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check("midrst.valid", {31'd0, coef_valid}, 32'd0);
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.rom_enable", {31'd0, rom_enable}, 32'd0);
        reset = 1'b0;
        run_load("post_rst", B0, B1, B2, B3, B4, 1'b0, 1'b0);

        // Stray ROM advance outside the loader; the tracker is offset to match.
        set_rom(A0, A1, A2, A3, A4);
        @(negedge clk);
        force dut.phase_q = 3'd1;
        stray = 1'b1;
        @(negedge clk);
        release dut.phase_q;
        stray = 1'b0;
        run_load("stray1", A1, A2, A3, A4, A0, 1'b1, 1'b0);
        run_load("stray2", A1, A2, A3, A4, A0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("stray.clear", {31'd0, phase_err}, 32'd0);
        reset = 1'b0;
        run_load("after_clear", A0, A1, A2, A3, A4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_coef_loader.md
Name: filter_coef_loader

Overview:
- Reader side of the rotating coefficient ROM interface.
- On request, it steps the ROM through one full rotation with a one-cycle-per-word `enable` strobe and captures each word into a named coefficient register (n1, n2, n3, d1, d2).
- It presents the coefficient bank in parallel to the IIR datapath, with valid/busy/done status.
- It leaves the ROM back at its home phase (n1 at the output).

Parameters:
- WIDTH, 32, coefficient word width (signed Q16.16).
- NUM_COEF, 5, words per rotation; fixed at 5. Elaboration error if any other value.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset. Shared with the ROM so both start at phase 0.
- start  input  1  load request; sampled only in IDLE.
- rom_data  input  WIDTH  ROM output word (signed); reflects the current ROM head.
- rom_enable  output  1  ROM advance strobe; registered.
- coef_n1, coef_n2, coef_n3, coef_d1, coef_d2  output  WIDTH each  signed coefficient bank.
- coef_valid  output  1  bank holds a complete, consistent coefficient set.
- busy  output  1  high in LOAD and DONE.
- done  output  1  one-cycle pulse when a load completes.
- phase_err  output  1  sticky; set if the internal ROM phase tracker is non-zero when a load starts.

Behaviour:
- Reset values: all coef_* = 0, coef_valid = 0, busy = 0, done = 0, rom_enable = 0, phase_err = 0, slot index = 0, ROM phase tracker = 0. State = IDLE.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start = 1 -> LOAD. Slot index = 0; busy goes high on the next cycle.
  - If the phase tracker is non-zero at that point, set phase_err. The load proceeds regardless.
- LOAD, one word per cycle, for slots 0..4:
  - Capture rom_data into the slot register: 0 = n1, 1 = n2, 2 = n3, 3 = d1, 4 = d2.
  - Assert rom_enable in the same cycle.
  - The ROM advances on the edge ending that cycle, so rom_data in the next cycle is the next word.
  - rom_enable is driven so that it is high exactly while in LOAD: 5 consecutive cycles, no gaps.
  - After slot 4 -> DONE.
- DONE (one cycle):
  - done = 1, coef_valid = 1, rom_enable = 0.
  - Then -> IDLE.
  - Latency: start seen in cycle T -> captures in T+1..T+5 -> done in T+6 -> ready for the next start in T+7.
- Phase tracker:
  - Mod-5 counter, incremented on every cycle rom_enable is high.
  - After a complete load it returns to 0 (5 advances), so the ROM head is again n1.
- start while busy: ignored, not queued.
- start held high continuously: back-to-back loads, each separated by one IDLE cycle.
- Reset mid-load: immediate return to reset values. The ROM is also reset, so phase alignment is preserved. No partial set is ever flagged valid.
- Arithmetic: data is captured verbatim; no sign extension or rounding. Sign is preserved, e.g. 0xFFFE2EF4 reads back as 0xFFFE2EF4.
- phase_err clears only on reset.

Optional Feature:
- Macro: FILTER_COEF_LOADER_DBUF_EN.
- Defined:
  - LOAD captures into five shadow registers; coef_* outputs are unchanged during LOAD.
  - All five outputs commit simultaneously in the DONE cycle.
  - coef_valid, once set, stays high through later reloads; the datapath never sees a mixed set.
- Not defined:
  - Each coef_* output updates in the cycle after its slot is captured.
  - coef_valid deasserts in the cycle after start is accepted and reasserts in DONE.
- In both builds, done timing and rom_enable timing are identical.

Test Plan:
- Bench ROM model reset to {0x00010000, 0xFFFE2EF4, 0x0000E0F9, 0x0001E339, 0xFFFF1C99}; start pulse after reset -> 5 consecutive rom_enable cycles; done pulse exactly 6 cycles after start; coef_n1..d2 equal those five values; coef_valid = 1; phase_err = 0; ROM head back at 0x00010000.
- Second load with ROM contents unchanged -> identical bank; phase_err stays 0. start pulsed during LOAD -> no extra rom_enable (total 5 per load).
- Assert reset in the 3rd LOAD cycle -> all outputs 0 next cycle, coef_valid = 0; a subsequent full load yields the correct bank.
- Bench forces one stray ROM advance outside the loader (tracker model offset by 1), then start -> phase_err = 1 and remains 1 until reset.
- With FILTER_COEF_LOADER_DBUF_EN: preload bank A, then reload with ROM holding bank B -> coef_* show A through LOAD, switch to B all at once in the DONE cycle; coef_valid never drops.
- Without the macro: same stimulus -> coef_valid = 0 during LOAD and coef_n1 changes one cycle after the first capture.
